bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 85 ++++++++
 tb/tb_bin2bcd_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
//   state_t      : converter FSM states (IDLE, CONV, FIN)
//   ADJ_THRESH   : digit value at or above which the +3 correction is applied
//   ADJ_ADD      : correction added before each shift
//   int_digits() : decimal digits needed to hold 2^w-1
//   pow10()      : 10^d, used as the overflow threshold
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD = 4'd3;
    function automatic int int_digits(input int w);
        longint unsigned m;
        int d;
        m = (64'd1 << w) - 64'd1;
        d = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            d++;
        end
        return d;
    endfunction
    function automatic longint unsigned pow10(input int d);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p;
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: single-digit double-dabble correction (d >= 5 ? d + 3 : d).
//   d : current BCD digit of the scratch register
//   q : corrected digit, ready to be shifted left
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= ADJ_THRESH) ? d + ADJ_ADD : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   start : conversion request, accepted in IDLE or FIN
//   bin   : binary value, captured on an accepted start
//   busy  : high while shifting
//   done  : one-cycle pulse when bcd/ovf have just been updated
//   bcd   : packed BCD result, most-significant digit in the top nibble
//   ovf   : captured value was >= 10^DIGITS
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 4,
    parameter bit SAT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);
    // Scratch is wide enough for 2^IN_W-1, so nothing is lost before the output is trimmed.
    localparam int INT_D = int_digits(IN_W);
    localparam int SW = 4 * INT_D;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam longint unsigned LIM = pow10(DIGITS);

    state_t state, state_n;
    logic [IN_W-1:0] shift, shift_n;
    logic [SW-1:0] scratch, scratch_n, adj;
    logic [SW+IN_W-1:0] cat_n;
    logic [CW-1:0] cnt;
    logic ovf_pend, accept, last;
    logic [4*DIGITS-1:0] res;

    for (genvar i = 0; i < INT_D; i++) begin : g_adj
        bcd_digit_adj u_adj (.d(scratch[4*i +: 4]), .q(adj[4*i +: 4]));
    end

    // The result is taken from the post-shift scratch so it lands on the edge entering FIN.
    always_comb begin
        accept    = start && (state == IDLE || state == FIN);
        last      = (state == CONV) && (cnt == CW'(IN_W - 1));
        cat_n     = {adj, shift} << 1;
        scratch_n = cat_n[SW+IN_W-1:IN_W];
        shift_n   = cat_n[IN_W-1:0];
        res       = (SAT && ovf_pend) ? {DIGITS{4'h9}} : (4*DIGITS)'(scratch_n);
        state_n   = accept ? CONV : (state == CONV) ? (last ? FIN : CONV) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                shift    <= bin;
                scratch  <= '0;
                cnt      <= '0;
                ovf_pend <= 64'(bin) >= LIM;
            end else if (state == CONV) begin
                shift   <= shift_n;
                scratch <= scratch_n;
                cnt     <= cnt + 1'b1;
            end
            if (last) begin
                bcd <= res;
                ovf <= ovf_pend;
            end
        end
    end

    assign busy = (state == CONV);
    assign done = (state == FIN);
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench driving a saturating and a wrapping converter in parallel.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] bin = '0;
    logic busy1, done1, ovf1, busy0, done0, ovf0;
    logic [15:0] bcd1, bcd0;
    logic [16:0] q1[$];
    logic [16:0] q0[$];
    logic [16:0] e;
    logic [15:0] pb1 = '0, pb0 = '0;
    logic po1 = 1'b0, po0 = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bin2bcd_seq #(.IN_W(16), .DIGITS(4), .SAT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );
    bin2bcd_seq #(.IN_W(16), .DIGITS(4), .SAT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division; ovf bit on top.
    function automatic logic [16:0] model(input int v, input bit sat);
        int r;
        logic [15:0] b;
        b = '0;
        if (sat && v >= 10000) return {1'b1, 16'h9999};
        r = v % 10000;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {(v >= 10000) ? 1'b1 : 1'b0, b};
    endfunction

    task automatic push(input int v);
        q1.push_back(model(v, 1'b1));
        q0.push_back(model(v, 1'b0));
    endtask

    task automatic wait_free();
        int n = 0;
        while ((busy1 || busy0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_free_timeout", 32'(n < 100), 1);
    endtask

    task automatic issue(input int v);
        wait_free();
        bin = 16'(v);
        start = 1'b1;
        push(v);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic lat(input int v);
        wait_free();
        bin = 16'(v);
        start = 1'b1;
        push(v);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("latency_busy_done", 32'({busy1, done1, busy0, done0}), (i < 17) ? 32'hA : 32'h5);
        end
    endtask

    always @(negedge clk) begin
        if (done1) begin
            chk("sat1_done_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("sat1_result", 32'({ovf1, bcd1}), 32'(e));
            end
        end else if (rst_n) chk("sat1_hold", 32'({ovf1, bcd1}), 32'({po1, pb1}));
        if (done0) begin
            chk("sat0_done_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("sat0_result", 32'({ovf0, bcd0}), 32'(e));
            end
        end else if (rst_n) chk("sat0_hold", 32'({ovf0, bcd0}), 32'({po0, pb0}));
        pb1 = bcd1;
        po1 = ovf1;
        pb0 = bcd0;
        po0 = ovf0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t_prev;
        int b2b[2] = '{4095, 10001};
        rst_n = 1'b0;
        start = 1'b1;
        bin = 16'd1234;
        repeat (2) @(negedge clk);
        chk("reset_state_sat1", 32'({busy1, done1, ovf1, bcd1}), 0);
        chk("reset_state_sat0", 32'({busy0, done0, ovf0, bcd0}), 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("reset_no_start", 32'({busy1, done1, busy0, done0}), 0);

        lat(1234);
        issue(0);
        issue(9999);
        issue(10000);
        issue(65535);

        issue(42);
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin = 16'd777;
        @(negedge clk);
        start = 1'b0;

        wait_free();
        start = 1'b1;
        bin = 16'd321;
        push(321);
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done1 && n < 40);
            chk("b2b_done_seen", 32'(done1), 1);
            if (k > 0) chk("b2b_spacing", 32'(cyc - t_prev), 17);
            t_prev = cyc;
            if (k < 2) begin
                bin = 16'(b2b[k]);
                push(b2b[k]);
            end else start = 1'b0;
        end

        issue(4321);
        bin = 16'd9876;

        issue(5555);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        q1.delete();
        q0.delete();
        @(negedge clk);
        chk("midrst_busy", 32'({busy1, busy0}), 0);
        chk("midrst_bcd", 32'({ovf1, bcd1, ovf0, bcd0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        lat(5555);

        for (int i = 0; i < 1200; i++) issue(int'($urandom_range(0, 65535)));

        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sat1", 32'(q1.size()), 0);
        chk("drain_sat0", 32'(q0.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
